// File: rtl/addr_reg_bank_pkg.sv
// Shared definitions for the address-register bank: function codes and
// the select-width helper used by the interface and the top level.
package arf_pkg;

    typedef enum logic [2:0] {
        FS_DEC        = 3'b000,
        FS_INC        = 3'b001,
        FS_LOAD       = 3'b010,
        FS_CLR        = 3'b011,
        FS_LOADLO_CLR = 3'b100,
        FS_WRLO       = 3'b101,
        FS_WRHI       = 3'b110,
        FS_SEXT       = 3'b111
    } fun_e;

    // Width of a read-select index; never below one bit.
    function automatic int clog2_sel(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/addr_reg_bank_if.sv
// Control/data bundle between the address mux side (master) and the
// register bank (slave).
interface addr_reg_bank_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 4
);
    import arf_pkg::*;

    localparam int SEL_W = clog2_sel(NUM_REGS);

    logic [NUM_REGS-1:0] RegEn;
    logic [2:0]          FunSel;
    logic [WIDTH-1:0]    I;
    logic [SEL_W-1:0]    OutASel;
    logic [SEL_W-1:0]    OutBSel;
    logic                FlagClr;
    logic [WIDTH-1:0]    OutA;
    logic [WIDTH-1:0]    OutB;
    logic [NUM_REGS-1:0] Wrap;
    logic                StackOvf;
    logic                StackUnf;

    modport master (
        output RegEn, FunSel, I, OutASel, OutBSel, FlagClr,
        input  OutA, OutB, Wrap, StackOvf, StackUnf
    );

    modport slave (
        input  RegEn, FunSel, I, OutASel, OutBSel, FlagClr,
        output OutA, OutB, Wrap, StackOvf, StackUnf
    );

endinterface

// File: rtl/addr_reg_bank_cell.sv
// One address register: FunSel decode, reset value, and indicators that
// the current code would wrap the register (increment past all-ones or
// decrement below zero).
module arf_cell
    import arf_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_en,
    input  logic [2:0]       i_fun,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q,
    output logic             o_carry,
    output logic             o_borrow
);
    localparam int               H   = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    // Next-value decode for every function code.
    always_comb begin
        w_next = r_q;
        case (i_fun)
            FS_DEC:        w_next = r_q - ONE;
            FS_INC:        w_next = r_q + ONE;
            FS_LOAD:       w_next = i_data;
            FS_CLR:        w_next = '0;
            FS_LOADLO_CLR: w_next = {{(WIDTH-H){1'b0}}, i_data[H-1:0]};
            FS_WRLO:       w_next = {r_q[WIDTH-1:H], i_data[H-1:0]};
            FS_WRHI:       w_next = {i_data[H-1:0], r_q[H-1:0]};
            FS_SEXT:       w_next = {{(WIDTH-H){i_data[H-1]}}, i_data[H-1:0]};
            default:       w_next = r_q;
        endcase
    end

    // Register update; reset overrides any enabled operation.
    always_ff @(posedge Clock) begin
        if (Reset) r_q <= RESET_VAL;
        else if (i_en) r_q <= w_next;
    end

    assign o_q      = r_q;
    assign o_carry  = (i_fun == FS_INC) && (&r_q);
    assign o_borrow = (i_fun == FS_DEC) && (r_q == '0);

endmodule

// File: rtl/addr_reg_bank.sv
// Address-register bank: NUM_REGS cells sharing one function code, stack
// bound gating on the SP register, sticky wrap/stack flags and two
// combinational read ports.
module addr_reg_bank
    import arf_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               NUM_REGS = 4,
    parameter int               SP_INDEX = 3,
    parameter logic [WIDTH-1:0] SP_RESET = 16'hFFFF,
    parameter logic [WIDTH-1:0] SP_LOW   = 16'hFF00,
    parameter logic [WIDTH-1:0] SP_HIGH  = 16'hFFFF
) (
    input  logic             Clock,
    input  logic             Reset,
    addr_reg_bank_if.slave   rf
);
    logic [WIDTH-1:0]    w_q [NUM_REGS];
    logic [NUM_REGS-1:0] w_carry;
    logic [NUM_REGS-1:0] w_borrow;
    logic [NUM_REGS-1:0] w_en;
    logic [NUM_REGS-1:0] w_wrap_set;
    logic                w_ovf_set;
    logic                w_unf_set;
    logic [NUM_REGS-1:0] r_wrap;
    logic                r_ovf;
    logic                r_unf;
    logic [WIDTH-1:0]    w_outa;
    logic [WIDTH-1:0]    w_outb;

    // A push at the low bound or a pop at the high bound is refused.
    assign w_ovf_set = rf.RegEn[SP_INDEX] && (rf.FunSel == FS_DEC) && (w_q[SP_INDEX] == SP_LOW);
    assign w_unf_set = rf.RegEn[SP_INDEX] && (rf.FunSel == FS_INC) && (w_q[SP_INDEX] == SP_HIGH);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cell
        if (r == SP_INDEX) begin : g_sp
            assign w_en[r] = rf.RegEn[r] && !w_ovf_set && !w_unf_set;
        end else begin : g_gp
            assign w_en[r] = rf.RegEn[r];
        end

        arf_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL ((r == SP_INDEX) ? SP_RESET : {WIDTH{1'b0}})
        ) u_cell (
            .Clock    (Clock),
            .Reset    (Reset),
            .i_en     (w_en[r]),
            .i_fun    (rf.FunSel),
            .i_data   (rf.I),
            .o_q      (w_q[r]),
            .o_carry  (w_carry[r]),
            .o_borrow (w_borrow[r])
        );
    end

    // Wrap events on general registers only; SP never reports wrap.
    always_comb begin
        w_wrap_set = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wrap_set[r] = (r != SP_INDEX) && rf.RegEn[r] && (w_carry[r] || w_borrow[r]);
        end
    end

    // Sticky flags: clear request first, new events win over it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wrap <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_wrap <= (r_wrap & {NUM_REGS{~rf.FlagClr}}) | w_wrap_set;
            r_ovf  <= (r_ovf & ~rf.FlagClr) | w_ovf_set;
            r_unf  <= (r_unf & ~rf.FlagClr) | w_unf_set;
        end
    end

    // Read port A; out-of-range index reads as zero.
    always_comb begin
        w_outa = '0;
        if (int'(rf.OutASel) < NUM_REGS) w_outa = w_q[rf.OutASel];
    end

    // Read port B; out-of-range index reads as zero.
    always_comb begin
        w_outb = '0;
        if (int'(rf.OutBSel) < NUM_REGS) w_outb = w_q[rf.OutBSel];
    end

    assign rf.OutA     = w_outa;
    assign rf.OutB     = w_outb;
    assign rf.Wrap     = r_wrap;
    assign rf.StackOvf = r_ovf;
    assign rf.StackUnf = r_unf;

endmodule
